prince_inv_sbox_cms: RTL

- First-order CMS-masked PRINCE inverse S-box, 4-bit nibble, two Boolean input shares in, two shares out.
- Partner of the forward CMS S-box; used in the PRINCE decryption datapath and in the middle round of the reflection.
- Two register stages:
  - Stage 1 computes 8 CMS output-share domains per bit.
  - Stage 2 ring-refreshes the domains with fresh randomness.
  - Output compresses 8 domains to 2 shares.
- Valid/ready streaming interface with backpressure.

---
 rtl/prince_cms_pkg.sv | 46 ++++
 rtl/prince_inv_sbox_cms_bit.sv | 18 +
 rtl/prince_inv_sbox_cms.sv | 63 ++++++
 3 files changed

// File: rtl/prince_cms_pkg.sv
// Shared constants and helpers for the CMS-masked PRINCE inverse S-box.
// Domain i reads input bit k from share DOM_SEL[i][k].
package prince_cms_pkg;
  localparam int NDOM   = 8;
  localparam int RAND_W = NDOM * 4;

  typedef logic [NDOM-1:0] dom_vec_t;
  typedef logic [3:0]      nib_t;

  localparam nib_t SINV_LUT [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                     4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  // Bit 3 is the parity of bits 2..0, so any three input bits see all 8 share combinations.
  localparam nib_t DOM_SEL [NDOM] = '{4'h0, 4'h9, 4'hA, 4'h3, 4'hC, 4'h5, 4'h6, 4'hF};

  // Algebraic normal form of one output bit of Sinv (Moebius transform).
  function automatic logic [15:0] sinv_anf(input int b);
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = SINV_LUT[v][b];
    for (int k = 0; k < 4; k++)
      for (int v = 0; v < 16; v++)
        if (v[k]) t[v] = t[v] ^ t[v ^ (1 << k)];
    return t;
  endfunction

  // One domain's share of the ANF, with x already drawn from the domain's shares.
  function automatic logic dom_term(input logic [15:0] anf, input int dom, input nib_t x);
    logic acc;
    nib_t mm;
    int   fb;
    acc = (dom == 0) ? anf[0] : 1'b0;
    for (int m = 1; m < 16; m++) begin
      mm = nib_t'(m);
      fb = !mm[0] ? 0 : !mm[1] ? 1 : !mm[2] ? 2 : 3;
      if (anf[m]) begin
        case ($countones(mm))
          1:       if (dom == 0 || dom == NDOM-1) acc = acc ^ (&(x | ~mm));
          // quadratic terms only in the half of the domains where an unused bit reads share 0
          2:       if (!DOM_SEL[dom][fb]) acc = acc ^ (&(x | ~mm));
          default: acc = acc ^ (&(x | ~mm));
        endcase
      end
    end
    return acc;
  endfunction
endpackage

// File: rtl/prince_inv_sbox_cms_bit.sv
// CMS domain terms for one output bit of the PRINCE inverse S-box.
module prince_inv_sbox_cms_bit
  import prince_cms_pkg::*;
#(
  parameter int BIT = 0
) (
  input  nib_t     sh0,
  input  nib_t     sh1,
  output dom_vec_t dom
);
  localparam logic [15:0] ANF = sinv_anf(BIT);

  always_comb begin
    dom = '0;
    for (int i = 0; i < NDOM; i++)
      dom[i] = dom_term(ANF, i, (sh0 & ~DOM_SEL[i]) | (sh1 & DOM_SEL[i]));
  end
endmodule

// File: rtl/prince_inv_sbox_cms.sv
// Two-stage CMS-masked PRINCE inverse S-box with ring refresh and valid/ready flow.
// PRINCE_INV_SBOX_FLUSH_EN: zero pipeline data whenever a stage empties.
module prince_inv_sbox_cms
  import prince_cms_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  nib_t              in_sh0,
  input  nib_t              in_sh1,
  input  logic [RAND_W-1:0] rand_i,
  input  logic              rand_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output nib_t              out_sh0,
  output nib_t              out_sh1
);
  if (NDOM != 8) begin : g_ndom_chk
    $error("prince_inv_sbox_cms requires NDOM == 8");
  end

  dom_vec_t [3:0] dom, refr, pipe0, pipe1;
  logic v0, v1, adv1, load0;

  assign adv1      = v0 && rand_valid && (!v1 || out_ready);
  assign in_ready  = !v0 || adv1;
  assign load0     = in_valid && in_ready;
  assign out_valid = v1;

  for (genvar b = 0; b < 4; b++) begin : g_bit
    dom_vec_t r;
    prince_inv_sbox_cms_bit #(.BIT(b)) u_bit (
      .sh0 (in_sh0),
      .sh1 (in_sh1),
      .dom (dom[b])
    );
    assign r          = rand_i[b*NDOM +: NDOM];
    assign refr[b]    = pipe0[b] ^ r ^ {r[0], r[NDOM-1:1]};
    assign out_sh0[b] = ^pipe1[b][NDOM/2-1:0];
    assign out_sh1[b] = ^pipe1[b][NDOM-1:NDOM/2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      pipe0 <= '0;
      pipe1 <= '0;
    end else begin
      v0 <= load0 || (v0 && !adv1);
      v1 <= adv1 || (v1 && !out_ready);
      if (load0) pipe0 <= dom;
`ifdef PRINCE_INV_SBOX_FLUSH_EN
      else if (adv1) pipe0 <= '0;
`endif
      if (adv1) pipe1 <= refr;
`ifdef PRINCE_INV_SBOX_FLUSH_EN
      else if (out_ready) pipe1 <= '0;
`endif
    end
  end
endmodule
